// File: rtl/uart_tx_pacer_fifo.sv
// rtl/uart_tx_pacer_fifo.sv - RX-to-TX byte FIFO that paces tx_en pulses one UART frame apart
// Optional: define UART_FIFO_OVERWRITE_EN to overwrite the oldest entry on a write to a full FIFO.
module uart_tx_pacer_fifo #(
  parameter int Baud_Rate = 115200,
  parameter int Clk_Freq  = 50_000_000,
  parameter int DATA_LEN  = 8,
  parameter int DEPTH     = 16,
  parameter int GUARD_CYC = 16
) (
  input  logic                   clk_sys,
  input  logic                   rst,
  input  logic [DATA_LEN-1:0]    rx_dat,
  input  logic                   data_rdy,
  output logic [DATA_LEN-1:0]    tx_dat,
  output logic                   tx_en,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int GAP = (Clk_Freq / Baud_Rate) * (DATA_LEN + 2) + GUARD_CYC;
  localparam int TW  = (GAP >= 3) ? $clog2(GAP) : 1;

  localparam logic [TW-1:0] WAIT_LOAD = TW'(GAP - 3);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  if (GAP < 3) begin : g_gap_too_small
    $error("uart_tx_pacer_fifo: frame gap %0d is below the minimum of 3 cycles", GAP);
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_pacer_fifo: DEPTH %0d must be a power of two and at least 2", DEPTH);
  end

  logic [DATA_LEN-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [1:0]          state;
  logic [TW-1:0]       wait_cnt;

  logic          pop;
  logic          wr_fit;
  logic          wr_ovf;
  logic          mem_we;
  logic          rd_adv;
  logic [CW-1:0] count_nxt;

  // A pop in the same cycle frees a slot, so a write to a full FIFO still fits.
  always_comb begin
    pop    = (state == S_IDLE) && !empty;
    wr_fit = data_rdy && (!full || pop);
    wr_ovf = data_rdy && full && !pop;
`ifdef UART_FIFO_OVERWRITE_EN
    mem_we = wr_fit || wr_ovf;
    rd_adv = pop || wr_ovf;
`else
    mem_we = wr_fit;
    rd_adv = pop;
`endif
    count_nxt = fifo_count + CW'(wr_fit) - CW'(pop);
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (mem_we) wr_ptr <= wr_ptr + AW'(1);
      if (rd_adv) rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= count_nxt;
      empty      <= (count_nxt == '0);
      full       <= (count_nxt == FULL_CNT);
      overflow   <= wr_ovf;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (mem_we) mem[wr_ptr] <= rx_dat;
  end

  // SEND is the tx_en cycle; WAIT counts GAP-3 down to 0, giving GAP cycles pulse to pulse.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      tx_en    <= 1'b0;
      tx_dat   <= '0;
      wait_cnt <= '0;
    end else begin
      tx_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            tx_dat <= mem[rd_ptr];
            tx_en  <= 1'b1;
            state  <= S_SEND;
          end
        end
        S_SEND: begin
          wait_cnt <= WAIT_LOAD;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == '0) state <= S_IDLE;
          else                wait_cnt <= wait_cnt - TW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_pacer_fifo.sv
// tb/tb_uart_tx_pacer_fifo.sv - queue-model checked bench for uart_tx_pacer_fifo
module tb_uart_tx_pacer_fifo;
  localparam int BR  = 115200;
  localparam int CF  = 1_152_000;
  localparam int DL  = 8;
  localparam int DP  = 16;
  localparam int GC  = 16;
  localparam int GAP = (CF / BR) * (DL + 2) + GC;

  logic                clk_sys;
  logic                rst;
  logic [DL-1:0]       rx_dat;
  logic                data_rdy;
  logic [DL-1:0]       tx_dat;
  logic                tx_en;
  logic [$clog2(DP):0] fifo_count;
  logic                empty;
  logic                full;
  logic                overflow;

  uart_tx_pacer_fifo #(
    .Baud_Rate(BR), .Clk_Freq(CF), .DATA_LEN(DL), .DEPTH(DP), .GUARD_CYC(GC)
  ) dut (
    .clk_sys(clk_sys), .rst(rst), .rx_dat(rx_dat), .data_rdy(data_rdy),
    .tx_dat(tx_dat), .tx_en(tx_en), .fifo_count(fifo_count),
    .empty(empty), .full(full), .overflow(overflow)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int n_vec = 0;
  int n_err = 0;

  // Reference: byte queue plus the earliest cycle the next pop may occur.
  logic [DL-1:0] q[$];
  int            cyc        = 0;
  int            ready_t    = 0;
  int            last_pulse = -1;
  logic          exp_en     = 1'b0;
  logic [DL-1:0] exp_dat    = '0;
  logic          exp_ovf    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("tx_en", 32'(tx_en), 32'(exp_en));
    check("tx_dat", 32'(tx_dat), 32'(exp_dat));
    check("fifo_count", 32'(fifo_count), q.size());
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("full", 32'(full), 32'(q.size() == DP));
    check("overflow", 32'(overflow), 32'(exp_ovf));
  endtask

  // Called just after a falling edge: check this cycle, drive it, predict the next.
  task automatic step(input logic dr, input logic [DL-1:0] d);
    logic pop_now;
    logic ovf_n;
    check_outputs();
    data_rdy = dr;
    rx_dat   = d;
    pop_now  = (q.size() != 0) && (cyc >= ready_t);
    ovf_n    = 1'b0;
    if (pop_now) begin
      exp_dat    = q.pop_front();
      ready_t    = cyc + GAP;
      last_pulse = cyc + 1;
    end
    if (dr) begin
      if (q.size() < DP) q.push_back(d);
      else begin
        ovf_n = 1'b1;
`ifdef UART_FIFO_OVERWRITE_EN
        void'(q.pop_front());
        q.push_back(d);
`endif
      end
    end
    exp_en  = pop_now;
    exp_ovf = ovf_n;
    cyc++;
    @(negedge clk_sys);
  endtask

  task automatic drain();
    while ((q.size() != 0) || (cyc < ready_t + 2)) step(1'b0, '0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    data_rdy = 1'b0;
    #1;
    check("rst_tx_en", 32'(tx_en), 32'd0);
    check("rst_tx_dat", 32'(tx_dat), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    q.delete();
    exp_en  = 1'b0;
    exp_dat = '0;
    exp_ovf = 1'b0;
    ready_t = cyc;
    @(negedge clk_sys);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    data_rdy = 1'b0;
    rx_dat   = '0;
    #2;
    do_reset();

    // Single byte
    step(1'b1, 8'h55);
    drain();

    // Three-byte burst: pulses GAP apart
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    step(1'b1, 8'h03);
    drain();

    // Overflow on the 18th back-to-back write
    for (int i = 0; i < 18; i++) step(1'b1, 8'(i));

    // Write while full in the exact pop cycle
    while (cyc < ready_t) step(1'b0, '0);
    step(1'b1, 8'hAA);
    drain();

    // Reset 100 cycles into a WAIT with 5 bytes queued
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i));
    while (cyc < last_pulse + 100) step(1'b0, '0);
    do_reset();
    step(1'b1, 8'h3C);
    drain();

    // Random traffic: heavy (keeps the FIFO full) then sparse
    repeat (1500) step($urandom_range(0, 99) < 45, 8'($urandom));
    drain();
    repeat (1500) step($urandom_range(0, 99) < 2, 8'($urandom));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_pacer_fifo.md
# uart_tx_pacer_fifo

- Byte buffer and transmit pacer between the UART receiver and the UART transmitter in the loopback path.
- Input side: accepts the receiver's `rx_dat`/`data_rdy` strobes into a circular FIFO.
- Output side: issues single-cycle `tx_en` pulses with a held `tx_dat`, no faster than one UART frame time apart.
- Result: back-to-back received bytes are never presented to a transmitter that is still shifting out the previous byte.

## Interface
- `Baud_Rate`, 115200, line rate in bit/s.
- `Clk_Freq`, 50_000_000, `clk_sys` frequency in Hz.
- `DATA_LEN`, 8, data bits per frame.
- `DEPTH`, 16, FIFO entries; power of two, ≥2.
- `GUARD_CYC`, 16, extra idle cycles appended to each frame gap.
- `clk_sys` in 1: system clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `rx_dat` in DATA_LEN: byte from receiver, valid when `data_rdy`=1.
- `data_rdy` in 1: write strobe; every cycle high is one write.
- `tx_dat` out DATA_LEN: byte to transmitter; registered, held until next pop.
- `tx_en` out 1: single-cycle registered start pulse to transmitter.
- `fifo_count` out $clog2(DEPTH)+1: entries currently stored.
- `empty` out 1: `fifo_count`==0.
- `full` out 1: `fifo_count`==DEPTH.
- `overflow` out 1: one-cycle pulse on a write to a full FIFO with no same-cycle pop.

## Operation
- Storage: DEPTH×DATA_LEN memory; `wr_ptr`/`rd_ptr` are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Frame gap: GAP = (Clk_Freq/Baud_Rate)×(DATA_LEN+2) + GUARD_CYC, integer division. Default 434×10+16 = 4356. GAP ≥ 3 is required; elaboration-time error otherwise.
- Pacer FSM, 3 states:
  - IDLE: if `fifo_count`≠0, pop: `tx_dat` ← mem[rd_ptr], `rd_ptr`+1, → SEND. Otherwise stay.
  - SEND: `tx_en`=1 for this cycle; load wait counter with GAP-3; → WAIT.
  - WAIT: decrement the counter; at 0 → IDLE. WAIT lasts GAP-2 cycles.
- Pulse spacing: consecutive `tx_en` pulses are exactly GAP cycles apart while the FIFO is non-empty.
- Write while not full: store at `wr_ptr`, `wr_ptr`+1.
- Pop and write in the same cycle: both happen; count unchanged. This holds when full (no overflow) and when count=1 (new byte retained).
- Write while full with no pop: byte handling per Configuration; `overflow`=1 for that cycle.
- Reset values: `tx_dat`=0, `tx_en`=0, `fifo_count`=0, `empty`=1, `full`=0, `overflow`=0, FSM=IDLE, pointers 0. Memory contents are not reset.
- Reset mid-operation: asynchronous and immediate. `tx_en` drops at once; queued bytes and an in-progress wait are discarded.

## Timing
- Latency into an empty FIFO, idle pacer:
  - `data_rdy` at cycle 0 → `fifo_count`=1 after edge 0.
  - Pop in cycle 1; `tx_dat` valid from cycle 2.
  - `tx_en`=1 in cycle 2 only.
- `fifo_count`, `empty` and `full` are registered and reflect the edge just taken.
- `overflow` is registered and high in the cycle after the rejected write.
- `tx_dat` is stable for the whole `tx_en` cycle and through the following WAIT.

## Configuration
- `UART_FIFO_OVERWRITE_EN` defined: a write to a full FIFO with no pop stores the new byte at `wr_ptr` and advances both pointers. The oldest entry is discarded, `fifo_count` stays DEPTH, and `overflow` pulses.
- Not defined: the new byte is dropped, pointers are unchanged, and `overflow` pulses.

## Test plan
- Single byte: `data_rdy` for one cycle with `rx_dat`=0x55 at cycle 0 → `tx_dat`=0x55 from cycle 2, `tx_en` high in cycle 2 only, `empty`=1 again after cycle 1.
- Burst: 0x01, 0x02, 0x03 on cycles 0–2 → three `tx_en` pulses at cycles 2, 4358, 8714 carrying 0x01, 0x02, 0x03.
- Overflow, macro undefined, defaults: write 0x00..0x11 on cycles 0–17 → `full`=1 after cycle 16, `overflow` pulse in cycle 18, output sequence 0x00..0x10 (0x11 lost).
- Overflow, macro defined, same stimulus → `overflow` pulse in cycle 18, output sequence 0x00, 0x02..0x11 (0x01 lost), `fifo_count` stays 16.
- Full with simultaneous pop: FIFO full, write 0xAA in the IDLE pop cycle → `fifo_count` stays 16, no `overflow`, 0xAA emitted last.
- Reset mid-WAIT: assert `rst` 100 cycles after a `tx_en` with 5 bytes queued → outputs go immediately to reset values. After release, a write of 0x3C gives `tx_en` with 0x3C two cycles later.
